// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, redirect/halt handling, output slot.
// Optional delivered-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStall,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    input  logic        iHalt,
    input  logic        iMemReady,
    input  logic [31:0] iMemData,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    output logic [31:0] oInstruction,
    output logic        oInstrValid,
    output logic [31:0] oPc,
    output logic        oHalted,
    output logic [31:0] oFetchCount
);

    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHalted
    } fetchStateT;

    fetchStateT  stateQ, stateD;
    logic [31:0] fetchPcQ, fetchPcD;
    logic [31:0] pendAddrQ, pendAddrD;
    logic        pendingQ, pendingD;
    logic        haltAfterQ, haltAfterD;
    logic [31:0] instrQ, instrD;
    logic [31:0] pcQ, pcD;
    logic        validQ, validD;
    logic        memReq;
    logic [31:0] memAddr;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateQ     <= StFetch;
            fetchPcQ   <= RESET_PC;
            pendAddrQ  <= RESET_PC;
            pendingQ   <= 1'b0;
            haltAfterQ <= 1'b0;
            instrQ     <= 32'h0;
            pcQ        <= RESET_PC;
            validQ     <= 1'b0;
        end else begin
            stateQ     <= stateD;
            fetchPcQ   <= fetchPcD;
            pendAddrQ  <= pendAddrD;
            pendingQ   <= pendingD;
            haltAfterQ <= haltAfterD;
            instrQ     <= instrD;
            pcQ        <= pcD;
            validQ     <= validD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        fetchPcD   = fetchPcQ;
        pendAddrD  = pendAddrQ;
        pendingD   = pendingQ;
        haltAfterD = haltAfterQ;
        instrD     = instrQ;
        pcD        = pcQ;
        validD     = validQ;
        memReq     = 1'b0;
        memAddr    = fetchPcQ;

        case (stateQ)
            StFetch: begin
                memReq  = pendingQ | !validQ | !iStall;
                memAddr = fetchPcQ;
                if (iRedirect) begin
                    // Redirect wins over a simultaneous halt.
                    fetchPcD = iRedirectPc;
                    validD   = 1'b0;
                    pendingD = 1'b0;
                    if (memReq && !iMemReady) begin
                        stateD     = StDrain;
                        pendAddrD  = fetchPcQ;
                        haltAfterD = 1'b0;
                    end
                end else if (iHalt) begin
                    validD   = 1'b0;
                    pendingD = 1'b0;
                    if (memReq && !iMemReady) begin
                        stateD     = StDrain;
                        pendAddrD  = fetchPcQ;
                        haltAfterD = 1'b1;
                    end else begin
                        stateD = StHalted;
                    end
                end else if (memReq && iMemReady) begin
                    instrD   = iMemData;
                    pcD      = fetchPcQ;
                    validD   = 1'b1;
                    fetchPcD = fetchPcQ + 32'd1;
                    pendingD = 1'b0;
                end else begin
                    // An unanswered request must stay raised on the same address.
                    pendingD = memReq;
                    if (!iStall) begin
                        validD = 1'b0;
                    end
                end
            end
            StDrain: begin
                memReq  = 1'b1;
                memAddr = pendAddrQ;
                validD  = 1'b0;
                if (iRedirect) begin
                    fetchPcD = iRedirectPc;
                end
                if (iMemReady) begin
                    pendingD = 1'b0;
                    stateD   = haltAfterQ ? StHalted : StFetch;
                end
            end
            StHalted: begin
                validD = 1'b0;
            end
            default: begin
                stateD = StFetch;
                validD = 1'b0;
            end
        endcase
    end

    // Reset must hold the request low even though the idle FETCH state would raise it.
    assign oMemReq      = iRst_n & memReq;
    assign oMemAddr     = memAddr;
    assign oInstruction = instrQ;
    assign oInstrValid  = validQ;
    assign oPc          = pcQ;
    assign oHalted      = (stateQ == StHalted);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCountQ;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fetchCountQ <= 32'h0;
        end else if (validQ && !iStall && (stateQ != StHalted)) begin
            fetchCountQ <= fetchCountQ + 32'd1;
        end
    end

    assign oFetchCount = fetchCountQ;
`else
    assign oFetchCount = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch, plus hand sequences for reset and PC wrap.
module tb_instr_fetch;

    logic        clk;
    logic        rstN;
    logic        stall, redirect, halt, memReady;
    logic [31:0] redirectPc, memData;
    logic        memReq, instrValid, halted;
    logic [31:0] memAddr, instruction, pc, fetchCount;

    logic        memReq2, instrValid2, halted2;
    logic [31:0] memAddr2, instruction2, pc2, fetchCount2;
    logic        zero2, one2;
    logic [31:0] zeroPc2, data2;

`ifdef FETCH_PERF_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    int nTests = 0;
    int nFail  = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .iClk(clk), .iRst_n(rstN), .iStall(stall), .iRedirect(redirect),
        .iRedirectPc(redirectPc), .iHalt(halt), .iMemReady(memReady), .iMemData(memData),
        .oMemReq(memReq), .oMemAddr(memAddr), .oInstruction(instruction),
        .oInstrValid(instrValid), .oPc(pc), .oHalted(halted), .oFetchCount(fetchCount)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFF)) dutWrap (
        .iClk(clk), .iRst_n(rstN), .iStall(zero2), .iRedirect(zero2),
        .iRedirectPc(zeroPc2), .iHalt(zero2), .iMemReady(one2), .iMemData(data2),
        .oMemReq(memReq2), .oMemAddr(memAddr2), .oInstruction(instruction2),
        .oInstrValid(instrValid2), .oPc(pc2), .oHalted(halted2), .oFetchCount(fetchCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        halt;
        logic        ready;
        logic [31:0] data;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInstr;
        logic        eHalted;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int expCount;
        rstN = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; memReady = 1'b0;
        redirectPc = 32'h0; memData = 32'h0;
        zero2 = 1'b0; one2 = 1'b1; zeroPc2 = 32'h0; data2 = 32'h5A5A_0000;

        //             stall rdr rpc          halt rdy data          req addr         val pc           instr        hlt
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0000, 1, 32'h0,  0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0001, 1, 32'h1,  1, 32'h0,  32'hC000_0000, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0002, 1, 32'h2,  1, 32'h1,  32'hC000_0001, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0003, 1, 32'h3,  1, 32'h2,  32'hC000_0002, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0004, 1, 32'h4,  1, 32'h3,  32'hC000_0003, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'h0000_0000, 1, 32'h5,  1, 32'h4,  32'hC000_0004, 0});
        vecs.push_back('{1, 0, 32'h0,  0, 1, 32'hC000_0006, 0, 32'h6,  1, 32'h5,  32'h0,         0});
        vecs.push_back('{1, 0, 32'h0,  0, 1, 32'hC000_0006, 0, 32'h6,  1, 32'h5,  32'h0,         0});
        vecs.push_back('{1, 0, 32'h0,  0, 1, 32'hC000_0006, 0, 32'h6,  1, 32'h5,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0006, 1, 32'h6,  1, 32'h5,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,         1, 32'h7,  1, 32'h6,  32'hC000_0006, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,         1, 32'h7,  0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0007, 1, 32'h7,  0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,         1, 32'h8,  1, 32'h7,  32'hC000_0007, 0});
        vecs.push_back('{0, 1, 32'h40, 0, 0, 32'h0,         1, 32'h8,  0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,         1, 32'h8,  0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hDEAD_BEEF, 1, 32'h8,  0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0040, 1, 32'h40, 0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0041, 1, 32'h41, 1, 32'h40, 32'hC000_0040, 0});
        vecs.push_back('{0, 1, 32'h10, 1, 1, 32'hC000_0042, 1, 32'h42, 1, 32'h41, 32'hC000_0041, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0010, 1, 32'h10, 0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hC000_0011, 1, 32'h11, 1, 32'h10, 32'hC000_0010, 0});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h0,         1, 32'h12, 1, 32'h11, 32'hC000_0011, 0});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,         1, 32'h12, 0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'hFFFF_FFFF, 1, 32'h12, 0, 32'h0,  32'h0,         0});
        vecs.push_back('{0, 0, 32'h0,  0, 1, 32'h0,         0, 32'h0,  0, 32'h0,  32'h0,         1});
        vecs.push_back('{0, 1, 32'h80, 0, 1, 32'h0,         0, 32'h0,  0, 32'h0,  32'h0,         1});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,         0, 32'h0,  0, 32'h0,  32'h0,         1});

        // Reset state, sampled while reset is still asserted.
        step();
        step();
        check("reset memReq", {31'h0, memReq}, 32'h0);
        check("reset instrValid", {31'h0, instrValid}, 32'h0);
        check("reset pc", pc, 32'h0);
        check("reset instruction", instruction, 32'h0);
        check("reset halted", {31'h0, halted}, 32'h0);
        check("reset fetchCount", fetchCount, 32'h0);
        check("reset wrap pc", pc2, 32'hFFFF_FFFF);
        check("reset wrap memReq", {31'h0, memReq2}, 32'h0);

        rstN = 1'b1;
        expCount = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            stall = vecs[k].stall; redirect = vecs[k].redirect; redirectPc = vecs[k].rpc;
            halt = vecs[k].halt; memReady = vecs[k].ready; memData = vecs[k].data;
            @(negedge clk);
            check($sformatf("row%0d memReq", k), {31'h0, memReq}, {31'h0, vecs[k].eReq});
            if (vecs[k].eReq)
                check($sformatf("row%0d memAddr", k), memAddr, vecs[k].eAddr);
            check($sformatf("row%0d instrValid", k), {31'h0, instrValid},
                  {31'h0, vecs[k].eValid});
            if (vecs[k].eValid) begin
                check($sformatf("row%0d pc", k), pc, vecs[k].ePc);
                check($sformatf("row%0d instruction", k), instruction, vecs[k].eInstr);
            end
            check($sformatf("row%0d halted", k), {31'h0, halted}, {31'h0, vecs[k].eHalted});
            check($sformatf("row%0d fetchCount", k), fetchCount, CntEn ? expCount : 0);
            if (vecs[k].eValid && !vecs[k].stall)
                expCount++;
            step();
        end

        // Reset in the middle of an unanswered request abandons it.
        stall = 1'b0; redirect = 1'b0; halt = 1'b0; memReady = 1'b0; memData = 32'h0;
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        @(negedge clk);
        check("rst1 memReq", {31'h0, memReq}, 32'h1);
        check("rst1 memAddr", memAddr, 32'h0);
        check("rst1 halted", {31'h0, halted}, 32'h0);
        step();
        @(negedge clk);
        check("rst1 pending memAddr", memAddr, 32'h0);
        #1 rstN = 1'b0;
        #1;
        check("rst async memReq", {31'h0, memReq}, 32'h0);
        check("rst async instrValid", {31'h0, instrValid}, 32'h0);
        step();
        rstN = 1'b1; memReady = 1'b1; memData = 32'h1234_5678;
        @(negedge clk);
        check("rst2 memReq", {31'h0, memReq}, 32'h1);
        check("rst2 memAddr", memAddr, 32'h0);
        check("rst2 instrValid", {31'h0, instrValid}, 32'h0);
        step();
        @(negedge clk);
        check("rst2 deliver valid", {31'h0, instrValid}, 32'h1);
        check("rst2 deliver pc", pc, 32'h0);
        check("rst2 deliver instruction", instruction, 32'h1234_5678);

        // Fetch PC wrap with RESET_PC at the top of the address space.
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        @(negedge clk);
        check("wrap c0 memReq", {31'h0, memReq2}, 32'h1);
        check("wrap c0 memAddr", memAddr2, 32'hFFFF_FFFF);
        check("wrap c0 valid", {31'h0, instrValid2}, 32'h0);
        step();
        @(negedge clk);
        check("wrap c1 memAddr", memAddr2, 32'h0000_0000);
        check("wrap c1 pc", pc2, 32'hFFFF_FFFF);
        check("wrap c1 instruction", instruction2, 32'h5A5A_0000);
        check("wrap c1 fetchCount", fetchCount2, 32'h0);
        step();
        @(negedge clk);
        check("wrap c2 memAddr", memAddr2, 32'h1);
        check("wrap c2 pc", pc2, 32'h0);
        check("wrap c2 fetchCount", fetchCount2, CntEn ? 32'd1 : 32'd0);
        step();
        @(negedge clk);
        check("wrap c3 fetchCount", fetchCount2, CntEn ? 32'd3 - 32'd1 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
